simple_mem_store: RTL and testbench
===================================

// Module: simple_mem_store
// PURPOSE
//  Downstream stage of the APB slave: the target of the simple memory request interface.
//  Holds a DEPTH x DATA_W register-file store.
//  Services one read or write per request after a programmable wait-state latency; stall_i can add wait states.
//  Completion is a one-cycle ready pulse; read data is registered and stays stable afterwards.
// PARAMETERS
//  ADDR_W   4   address width; DEPTH = 2**ADDR_W = 16 words
//  DATA_W   32  data width
//  LAT      2   wait-state cycles between accept and ready (0..15)
// PORTS
//  clk              in   1       clock, rising edge
//  reset            in   1       asynchronous, active-high
//  mem_req_i        in   1       request valid; held high by requester until ready seen
//  mem_req_rnw_i    in   1       1 = read, 0 = write
//  mem_req_addr_i   in   ADDR_W  word address
//  mem_req_wdata_i  in   DATA_W  write data
//  stall_i          in   1       freezes latency countdown (wait-state injection)
//  mem_req_ready_o  out  1       completion pulse, exactly one cycle per request
//  mem_req_rdata_o  out  DATA_W  read data, valid from the ready cycle until the next read completes
//  busy_o           out  1       high in BUSY and RESP states
// BEHAVIOUR
//  Reset (async):
//   - state = IDLE; all outputs 0; cnt = 0; whole array cleared to 0.
//   - A pending write is dropped when reset arrives mid-operation.
//  FSM states:
//   - IDLE: when mem_req_i = 1, capture rnw, addr and wdata into q-regs and set cnt <= LAT.
//     Go to RESP if LAT == 0, otherwise go to BUSY.
//   - BUSY: when stall_i = 0, decrement cnt; when cnt == 1, go to RESP. stall_i = 1 holds cnt and state.
//   - RESP: mem_req_ready_o = 1 for this cycle only.
//     On exit, go to HOLD if mem_req_i = 1, else go to IDLE.
//   - HOLD: wait for mem_req_i = 0, then go to IDLE. Absorbs the requester's trailing
//     request cycle after ready; that cycle is never treated as a new request.
//  Side effects on the edge entering RESP:
//   - Write: array[q_addr] <= q_wdata.
//   - Read: mem_req_rdata_o <= array[q_addr]. rdata is not changed by writes.
//  Latency:
//   - Ready is high during cycle N+LAT+1, where N is the accept edge, plus one cycle per stalled BUSY cycle.
//   - stall_i is ignored in IDLE, RESP and HOLD.
//  Input stability:
//   - Inputs are sampled only at accept; changes to addr, wdata or rnw in later cycles have no effect.
//  Outputs:
//   - mem_req_ready_o and busy_o are registered from the state (next-state decode), with no combinational path from inputs.
//   - Only one request is in flight; the block is single-ported with no pipelining.
//  Width and range:
//   - cnt is 4 bits.
//   - Every ADDR_W address is valid; there is no error response.
//  Back-to-back requests:
//   - A new request needs mem_req_i low for at least one cycle.
//   - Minimum spacing: accept, LAT, RESP, then either HOLD or IDLE.
// STRUCTURE
//  Package simple_mem_pkg:
//   - mem_state_t enum {IDLE, BUSY, RESP, HOLD}
//   - MEM_ADDR_W = 4, MEM_DATA_W = 32, MEM_DEF_LAT = 2
//  Sub-module mem_regfile:
//   - DEPTH x DATA_W array with async clear.
//   - One synchronous write port (we, waddr, wdata) and one combinational read port (raddr -> rdata).
//  Top level: FSM, latency counter, capture registers, and the rdata/ready output registers.
// TESTING
//  1. Reset mid-BUSY:
//     - Write addr 3 = 0xDEADBEEF, assert reset during BUSY.
//     - Then read addr 3 -> rdata 0x00000000; ready never pulses for the aborted write.
//  2. Basic write/read with LAT=2:
//     - Write addr 5 = 0xA5A5_0001 -> ready high 3 cycles after accept.
//     - Read addr 5 -> rdata 0xA5A5_0001 in the ready cycle.
//  3. Stall:
//     - Read with stall_i high for 4 BUSY cycles -> ready at accept+7.
//     - Exactly one ready pulse; busy_o high the whole time.
//  4. Trailing request:
//     - Requester holds mem_req_i one cycle past ready (APB slave pattern).
//     - FSM passes through HOLD; no second access and no second ready.
//  5. Address wrap:
//     - Write addr 15 = 0x1, then addr 0 = 0x2; read back both -> 0x1 and 0x2, no aliasing.
//     - Inputs toggled after accept are ignored.
//  6. LAT=0 build:
//     - Ready in the cycle after accept.
//     - Read after a write to the same address returns the new data; rdata is held across a following write.

Source files
------------

// File: rtl/simple_mem_pkg.sv
// Shared types and defaults for the simple memory request target.
// The state encoding is used by the top-level FSM and its output decode.
package simple_mem_pkg;

    localparam int MEM_ADDR_W  = 4;
    localparam int MEM_DATA_W  = 32;
    localparam int MEM_DEF_LAT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } mem_state_t;

    // busy_o covers the wait-state countdown and the completion cycle
    function automatic logic mem_busy_state(input mem_state_t st);
        return (st == BUSY) || (st == RESP);
    endfunction

endpackage

// File: rtl/simple_mem_store_regfile.sv
// DEPTH x DATA_W register-file store: one synchronous write port,
// one combinational read port, whole array cleared by asynchronous reset.
module mem_regfile #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage array: cleared on reset, written when the write port is enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/simple_mem_store.sv
// Target of the simple memory request interface: accepts one request at a
// time, waits LAT (plus stalled) cycles, then pulses ready for one cycle.
module simple_mem_store
    import simple_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int LAT    = MEM_DEF_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req_i,
    input  logic              mem_req_rnw_i,
    input  logic [ADDR_W-1:0] mem_req_addr_i,
    input  logic [DATA_W-1:0] mem_req_wdata_i,
    input  logic              stall_i,
    output logic              mem_req_ready_o,
    output logic [DATA_W-1:0] mem_req_rdata_o,
    output logic              busy_o
);

    localparam logic [3:0] LAT_C = 4'(LAT);

    mem_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rnw_q, rnw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              eff_rnw_s;
    logic [ADDR_W-1:0] eff_addr_s;
    logic [DATA_W-1:0] eff_wdata_s;
    logic              enter_resp_s;
    logic              rf_we_s;
    logic [DATA_W-1:0] rf_rdata_s;

    // With LAT == 0 the access happens on the accept edge itself, so the
    // live inputs stand in for the capture registers while in IDLE.
    always_comb begin
        if (state_q == IDLE) begin
            eff_rnw_s   = mem_req_rnw_i;
            eff_addr_s  = mem_req_addr_i;
            eff_wdata_s = mem_req_wdata_i;
        end else begin
            eff_rnw_s   = rnw_q;
            eff_addr_s  = addr_q;
            eff_wdata_s = wdata_q;
        end
    end

    // Next-state, counter and capture-register decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    rnw_d   = mem_req_rnw_i;
                    addr_d  = mem_req_addr_i;
                    wdata_d = mem_req_wdata_i;
                    cnt_d   = LAT_C;
                    state_d = (LAT_C == 4'd0) ? RESP : BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!stall_i) begin
                    cnt_d = (cnt_q == 4'd0) ? 4'd0 : (cnt_q - 4'd1);
                    if (cnt_q <= 4'd1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            RESP: begin
                state_d = mem_req_i ? HOLD : IDLE;
            end
            HOLD: begin
                if (!mem_req_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign enter_resp_s = (state_d == RESP);
    assign rf_we_s      = enter_resp_s && !eff_rnw_s;

    // Output decode from the next state so the outputs are plain flops
    always_comb begin
        ready_d = enter_resp_s;
        busy_d  = mem_busy_state(state_d);
        if (enter_resp_s && eff_rnw_s) begin
            rdata_d = rf_rdata_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State, counter, capture and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    mem_regfile #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (rf_we_s),
        .waddr (eff_addr_s),
        .wdata (eff_wdata_s),
        .raddr (eff_addr_s),
        .rdata (rf_rdata_s)
    );

    assign mem_req_ready_o = ready_q;
    assign busy_o          = busy_q;
    assign mem_req_rdata_o = rdata_q;

endmodule

// File: tb/tb_simple_mem_store.sv
// Directed bench for simple_mem_store: a LAT=2 instance and a LAT=0 instance
// driven through one request task, all results compared against constants.
module tb_simple_mem_store;

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [2];
    logic        rnw   [2];
    logic        stall [2];
    logic [3:0]  addr  [2];
    logic [31:0] wdata [2];
    logic        ready [2];
    logic        busy  [2];
    logic [31:0] rdata [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simple_mem_store #(.ADDR_W(4), .DATA_W(32), .LAT(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_req_i       (req[0]),
        .mem_req_rnw_i   (rnw[0]),
        .mem_req_addr_i  (addr[0]),
        .mem_req_wdata_i (wdata[0]),
        .stall_i         (stall[0]),
        .mem_req_ready_o (ready[0]),
        .mem_req_rdata_o (rdata[0]),
        .busy_o          (busy[0])
    );

    simple_mem_store #(.ADDR_W(4), .DATA_W(32), .LAT(0)) dut_lat0 (
        .clk             (clk),
        .reset           (reset),
        .mem_req_i       (req[1]),
        .mem_req_rnw_i   (rnw[1]),
        .mem_req_addr_i  (addr[1]),
        .mem_req_wdata_i (wdata[1]),
        .stall_i         (stall[1]),
        .mem_req_ready_o (ready[1]),
        .mem_req_rdata_o (rdata[1]),
        .busy_o          (busy[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One request; inputs are inverted right after accept, lat is the ready
    // cycle counted from the accept edge (-1 if ready never came).
    task automatic run_req(input int s, input logic r, input logic [3:0] a,
                           input logic [31:0] d, input int stall_n, input bit trail,
                           output int lat, output int busy_low, output int extra,
                           output logic [31:0] rd);
        lat = -1; busy_low = 0; extra = 0; rd = 32'h0;
        @(negedge clk);
        req[s] = 1'b1; rnw[s] = r; addr[s] = a; wdata[s] = d;
        @(posedge clk);
        #1;
        rnw[s] = ~r; addr[s] = ~a; wdata[s] = ~d;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (busy[s] !== 1'b1) busy_low++;
            if (ready[s] === 1'b1) begin
                lat = c;
                rd  = rdata[s];
            end
            stall[s] = (c <= stall_n);
        end
        if (trail) begin
            @(negedge clk);
            if (ready[s] === 1'b1) extra++;
        end
        req[s] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ready[s] === 1'b1) extra++;
        end
        stall[s] = 1'b0; rnw[s] = 1'b0; addr[s] = 4'h0; wdata[s] = 32'h0;
    endtask

    int          lat, bl, ex;
    logic [31:0] rd;

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; rnw[i] = 1'b0; stall[i] = 1'b0; addr[i] = 4'h0; wdata[i] = 32'h0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("rst_ready%0d", i), {31'h0, ready[i]}, 32'h0);
            check_val($sformatf("rst_busy%0d", i),  {31'h0, busy[i]},  32'h0);
            check_val($sformatf("rst_rdata%0d", i), rdata[i],          32'h0);
        end
        reset = 1'b0;

        // Reset mid-BUSY drops the pending write and clears the array
        run_req(0, 1'b0, 4'd3, 32'h1111_1111, 0, 1'b0, lat, bl, ex, rd);
        check_val("t1_pre_lat", lat, 32'd3);
        @(negedge clk);
        req[0] = 1'b1; rnw[0] = 1'b0; addr[0] = 4'd3; wdata[0] = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        check_val("t1_busy", {31'h0, busy[0]}, 32'h1);
        reset = 1'b1; req[0] = 1'b0;
        @(negedge clk);
        check_val("t1_rst_ready", {31'h0, ready[0]}, 32'h0);
        check_val("t1_rst_busy",  {31'h0, busy[0]},  32'h0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("t1_no_ready", {31'h0, ready[0]}, 32'h0);
        end
        run_req(0, 1'b1, 4'd3, 32'h0, 0, 1'b0, lat, bl, ex, rd);
        check_val("t1_rd_lat", lat, 32'd3);
        check_val("t1_rdata", rd, 32'h0000_0000);

        // Basic write / read
        run_req(0, 1'b0, 4'd5, 32'hA5A5_0001, 0, 1'b0, lat, bl, ex, rd);
        check_val("t2_wr_lat", lat, 32'd3);
        check_val("t2_wr_busy", bl, 32'd0);
        check_val("t2_wr_extra", ex, 32'd0);
        run_req(0, 1'b1, 4'd5, 32'h0, 0, 1'b0, lat, bl, ex, rd);
        check_val("t2_rd_lat", lat, 32'd3);
        check_val("t2_rdata", rd, 32'hA5A5_0001);

        // Stall for four BUSY cycles
        run_req(0, 1'b1, 4'd5, 32'h0, 4, 1'b0, lat, bl, ex, rd);
        check_val("t3_lat", lat, 32'd7);
        check_val("t3_busy", bl, 32'd0);
        check_val("t3_extra", ex, 32'd0);
        check_val("t3_rdata", rd, 32'hA5A5_0001);

        // Trailing request cycle goes through HOLD; inverted inputs would
        // otherwise write ~data to address 10
        run_req(0, 1'b1, 4'd5, 32'h0, 0, 1'b1, lat, bl, ex, rd);
        check_val("t4_lat", lat, 32'd3);
        check_val("t4_extra", ex, 32'd0);
        check_val("t4_rdata_hold", rdata[0], 32'hA5A5_0001);
        run_req(0, 1'b1, 4'd10, 32'h0, 0, 1'b0, lat, bl, ex, rd);
        check_val("t4_no_access", rd, 32'h0000_0000);

        // Address wrap with inputs toggled after accept
        run_req(0, 1'b0, 4'd15, 32'h0000_0001, 0, 1'b0, lat, bl, ex, rd);
        run_req(0, 1'b0, 4'd0,  32'h0000_0002, 0, 1'b0, lat, bl, ex, rd);
        run_req(0, 1'b1, 4'd15, 32'h0, 0, 1'b0, lat, bl, ex, rd);
        check_val("t5_rd15", rd, 32'h0000_0001);
        run_req(0, 1'b1, 4'd0, 32'h0, 0, 1'b0, lat, bl, ex, rd);
        check_val("t5_rd0", rd, 32'h0000_0002);

        // LAT=0 instance: stall has no effect outside BUSY
        run_req(1, 1'b0, 4'd7, 32'h1234_5678, 2, 1'b0, lat, bl, ex, rd);
        check_val("t6_wr_lat", lat, 32'd1);
        check_val("t6_wr_extra", ex, 32'd0);
        run_req(1, 1'b1, 4'd7, 32'h0, 0, 1'b0, lat, bl, ex, rd);
        check_val("t6_rd_lat", lat, 32'd1);
        check_val("t6_rdata", rd, 32'h1234_5678);
        run_req(1, 1'b0, 4'd7, 32'h0BAD_F00D, 0, 1'b0, lat, bl, ex, rd);
        check_val("t6_rdata_held", rdata[1], 32'h1234_5678);
        run_req(1, 1'b1, 4'd7, 32'h0, 0, 1'b0, lat, bl, ex, rd);
        check_val("t6_rdata_new", rd, 32'h0BAD_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
